// File: rtl/tc_timer_if.sv
// tc_timer_if: CPU-side register bus and interrupt line of the timer.
// Latency: n/a (wires only); dout is combinational from addr in the timer.
// Backpressure: none; the bus carries no handshake and every write is taken.
interface tc_timer_if;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   modport master (output addr, output we, output din, input dout, input irq);
   modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/tc_timer.sv
// tc_timer: CPU-programmable down-counter with one-shot/auto-reload modes and IRQ; optional prescaler via TC_PRESCALE_EN.
// Latency: irq rises PRESET+2 edges after the CTRL write that sets EN (3 edges for PRESET=0); reads are combinational.
// Backpressure: none; a register write is accepted on every edge where we=1.
module tc_timer (
   input logic     clk,
   input logic     reset,
   tc_timer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;
   logic        tick;

   logic        im;
   logic [1:0]  mode;
   logic        en;

   assign im   = ctrl[3];
   assign mode = ctrl[2:1];
   assign en   = ctrl[0];

`ifdef TC_PRESCALE_EN
   logic [7:0]  prescale;
   logic [7:0]  psc_cnt;
   // A count step only happens when the prescale counter has run down.
   assign tick = (psc_cnt == 8'd0);
`else
   assign tick = 1'b1;
`endif

   assign bus.irq = im & irq_flag;

   // Combinational read mux; CTRL upper bits and unimplemented words read as zero.
   always_comb begin
      bus.dout = 32'd0;
      case (bus.addr)
         2'd0: bus.dout = {28'd0, ctrl};
         2'd1: bus.dout = preset;
         2'd2: bus.dout = count;
`ifdef TC_PRESCALE_EN
         2'd3: bus.dout = {24'd0, prescale};
`endif
         default: bus.dout = 32'd0;
      endcase
   end

   // Counter FSM and register file; CPU writes are applied last so they win over same-edge FSM updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
         prescale <= 8'd0;
         psc_cnt  <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (en) state <= LOAD;
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
`ifdef TC_PRESCALE_EN
               psc_cnt <= prescale;
`endif
            end
            CNT: begin
               if (tick) begin
                  // Stop at 0 instead of wrapping; PRESET=0 and 1 both expire on the first tick.
                  if (count > 32'd1) begin
                     count <= count - 32'd1;
                  end else begin
                     count    <= 32'd0;
                     irq_flag <= 1'b1;
                     state    <= INT;
                  end
`ifdef TC_PRESCALE_EN
                  psc_cnt <= prescale;
`endif
               end
`ifdef TC_PRESCALE_EN
               else begin
                  psc_cnt <= psc_cnt - 8'd1;
               end
`endif
            end
            INT: begin
               // Auto-reload drops the flag for a one-cycle pulse; one-shot (and 1x) disables and keeps it.
               if (mode == 2'b01) begin
                  irq_flag <= 1'b0;
               end else begin
                  ctrl[0] <= 1'b0;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (bus.we) begin
            case (bus.addr)
               2'd0: begin
                  ctrl     <= bus.din[3:0];
                  irq_flag <= 1'b0;
                  state    <= IDLE;
                  count    <= count;
               end
               2'd1: begin
                  preset   <= bus.din;
                  irq_flag <= 1'b0;
               end
`ifdef TC_PRESCALE_EN
               2'd3: prescale <= bus.din[7:0];
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: scoreboard bench for tc_timer; expected irq per cycle is queued when EN is written.
// Latency: samples on the falling edge, so "edge k" results are seen k negedges after the write edge.
// Backpressure: n/a.
module tb_tc_timer;

   logic clk;
   logic reset;
   int   tests_run;
   int   failed;
   bit   exp_q[$];

   tc_timer_if bus_if ();

   tc_timer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.addr = a;
      bus_if.din  = d;
      bus_if.we   = 1'b1;
      @(negedge clk);
      bus_if.we   = 1'b0;
      bus_if.din  = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.addr = a;
      #1;
      d = bus_if.dout;
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      tests_run++;
      if (d !== exp) begin
         failed++;
         $display("FAIL %s: read 0x%08h, expected 0x%08h", name, d, exp);
      end
   endtask

   // Reference irq timing derived from the documented latency/period formulas.
   task automatic push_irq(input int preset, input bit im, input bit reload, input int n);
      int first;
      first = (preset >= 1) ? preset + 2 : 3;
      for (int k = 1; k <= n; k++) begin
         bit e;
         if (!im)         e = 1'b0;
         else if (reload) e = (k >= first) && (((k - first) % (preset + 3)) == 0);
         else             e = (k >= first);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_zero(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(1'b0);
   endtask

   task automatic drain_irq(input string name);
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         bit e;
         @(negedge clk);
         k++;
         e = exp_q.pop_front();
         tests_run++;
         if (bus_if.irq !== e) begin
            failed++;
            $display("FAIL %s edge %0d: irq=%b expected %b", name, k, bus_if.irq, e);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus_if.we = 1'b0;
      bus_if.addr = 2'd0;
      bus_if.din = 32'd0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus_if.irq !== 1'b0) begin
         failed++;
         $display("FAIL reset_irq: irq=%b expected 0", bus_if.irq);
      end
      for (int a = 0; a < 4; a++) check_reg("reset_reg", 2'(a), 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_oneshot(input string name, input int preset, input logic [3:0] ctrl_val);
      bus_write(2'd1, 32'(preset));
      check_reg({name, "_preset"}, 2'd1, 32'(preset));
      bus_write(2'd0, {28'd0, ctrl_val});
      push_irq(preset, ctrl_val[3], 1'b0, preset + 8);
      drain_irq(name);
      check_reg({name, "_count"}, 2'd2, 32'd0);
      check_reg({name, "_ctrl"}, 2'd0, {28'd0, ctrl_val & 4'hE});
   endtask

   task automatic test_ctrl_clear();
      bus_write(2'd0, 32'h0);
      tests_run++;
      if (bus_if.irq !== 1'b0) begin
         failed++;
         $display("FAIL ctrl_clear_irq: irq=%b expected 0", bus_if.irq);
      end
      push_zero(10);
      drain_irq("ctrl_clear_hold");
      tests_run++;
      if (dut.state !== 2'd0) begin
         failed++;
         $display("FAIL ctrl_clear_state: state=%0d expected 0", dut.state);
      end
   endtask

   task automatic test_autoreload();
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'hB);
      push_irq(3, 1'b1, 1'b1, 30);
      drain_irq("autoreload");
      bus_write(2'd0, 32'h0);
   endtask

   task automatic test_no_im();
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'h1);
      push_zero(10);
      drain_irq("no_im");
      check_reg("no_im_ctrl", 2'd0, 32'h0);
      tests_run++;
      if (dut.irq_flag !== 1'b1) begin
         failed++;
         $display("FAIL no_im_flag: irq_flag=%b expected 1", dut.irq_flag);
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      int   n;
      bus_write(2'd1, 32'd100);
      bus_write(2'd0, 32'h9);
      n = 0;
      bus_read(2'd2, d);
      while (d != 32'd50 && n < 300) begin
         @(negedge clk);
         n++;
         bus_read(2'd2, d);
      end
      tests_run++;
      if (d !== 32'd50) begin
         failed++;
         $display("FAIL midcount_wait: COUNT=%0d expected 50 within 300 cycles", d);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if (bus_if.irq !== 1'b0) begin
         failed++;
         $display("FAIL midcount_reset_irq: irq=%b expected 0", bus_if.irq);
      end
      for (int a = 0; a < 4; a++) check_reg("midcount_reset_reg", 2'(a), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      push_zero(200);
      drain_irq("midcount_after_release");
      check_reg("midcount_count_after", 2'd2, 32'd0);
   endtask

   task automatic test_word3();
`ifdef TC_PRESCALE_EN
      int   cnt_exp [5];
      logic [31:0] d;
      cnt_exp = '{2, 2, 1, 1, 0};
      bus_write(2'd3, 32'h1);
      check_reg("prescale_read", 2'd3, 32'h1);
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'h9);
      @(negedge clk);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         bus_read(2'd2, d);
         tests_run++;
         if (d !== 32'(cnt_exp[k-2]) || bus_if.irq !== (k == 6)) begin
            failed++;
            $display("FAIL prescale edge %0d: COUNT=%0d irq=%b expected COUNT=%0d irq=%b",
                     k, d, bus_if.irq, cnt_exp[k-2], (k == 6));
         end
      end
      bus_write(2'd3, 32'h0);
      bus_write(2'd0, 32'h0);
`else
      bus_write(2'd3, 32'hFF);
      check_reg("word3_ignored", 2'd3, 32'h0);
`endif
   endtask

   task automatic test_count_write_ignored();
      bus_write(2'd1, 32'd7);
      bus_write(2'd0, 32'h0);
      bus_write(2'd2, 32'h1234);
      check_reg("count_write_ignored", 2'd2, 32'd0);
      check_reg("ctrl_upper_zero", 2'd0, 32'h0);
   endtask

   initial begin
      tests_run = 0;
      failed    = 0;
      test_reset();
      test_oneshot("oneshot_p3", 3, 4'h9);
      test_ctrl_clear();
      test_oneshot("oneshot_p0", 0, 4'h9);
      test_oneshot("oneshot_p1", 1, 4'h9);
      test_oneshot("mode1x_p2", 2, 4'hD);
      test_autoreload();
      test_no_im();
      test_count_write_ignored();
      test_word3();
      test_reset_midcount();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/tc_timer.md
TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: addr  input  2  word select, driven from the bus address bits [3:2].
REQ-004 SHALL have port: we  input  1  word write strobe, sampled on the rising edge.
REQ-005 SHALL have port: din  input  32  write data.
REQ-006 SHALL have port: dout  output  32  combinational read data for addr.
REQ-007 SHALL have port: irq  output  1  interrupt request to the CPU HWInt bit, equal to CTRL.IM AND irq_flag.

Function
REQ-008 SHALL decode the register map as: 0 CTRL {28'b0, IM[3], MODE[2:1], EN[0]}; 1 PRESET[31:0]; 2 COUNT[31:0], read-only; 3 PRESCALE (see Configuration).
REQ-009 SHALL read CTRL[31:4] as zero, and SHALL ignore writes to COUNT.
REQ-010 SHALL implement the states IDLE, LOAD, CNT and INT.
REQ-011 SHALL transition IDLE->LOAD when EN=1, and otherwise hold IDLE.
REQ-012 SHALL, in LOAD, set COUNT<=PRESET and go to CNT.
REQ-013 SHALL, in CNT with COUNT>1, set COUNT<=COUNT-1 and stay in CNT.
REQ-014 SHALL, in CNT with COUNT<=1, set COUNT<=0, set irq_flag and go to INT.
REQ-015 SHALL, in INT with MODE=00 (one-shot), clear EN and go to IDLE; irq_flag stays set.
REQ-016 SHALL, in INT with MODE=01 (auto-reload), clear irq_flag and go to IDLE; irq is therefore a one-cycle pulse per period.
REQ-017 SHALL treat MODE=1x as MODE=00.
REQ-018 SHALL, on a CPU write to CTRL, load CTRL from din[3:0], clear irq_flag and force the state to IDLE at that edge, overriding any same-edge counter update; COUNT is retained.
REQ-019 SHALL, on a CPU write to PRESET, update PRESET and clear irq_flag without changing the state; a count in progress is unaffected until the next LOAD.
REQ-020 SHALL produce irq timing as follows: after a write edge setting EN=1, irq first rises PRESET+2 edges later for PRESET>=1, and 3 edges later for PRESET=0.
REQ-021 SHALL give an auto-reload period of PRESET+3 cycles for PRESET>=1.
REQ-022 SHALL wrap no arithmetic, because COUNT never decrements below 0.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear CTRL, PRESET, COUNT, PRESCALE, the prescale counter and irq_flag, and set the state to IDLE; irq=0.
REQ-024 SHALL, on reset assertion mid-count, abort the count with no irq; after release the block stays in IDLE until EN is written.

Configuration
REQ-025 SHALL, with TC_PRESCALE_EN defined, implement PRESCALE[7:0] at word 3 (read {24'b0, PRESCALE}) and an internal prescale counter.
REQ-026 SHALL, with TC_PRESCALE_EN defined, decrement COUNT in CNT only when the prescale counter is 0, reloading the counter from PRESCALE on each decrement and in LOAD; each tick then lasts PRESCALE+1 cycles.
REQ-027 SHALL, without TC_PRESCALE_EN, read word 3 as 0, ignore writes to it, and decrement every cycle, with timing exactly as in REQ-020.

Verification
REQ-028 SHALL cover: PRESET=3, then CTRL=0x9 -> irq=1 from the 5th edge after the CTRL write onward and held; COUNT reads 0; CTRL reads 0x8.
REQ-029 SHALL cover: after REQ-028, a write to CTRL=0x0 -> irq=0 on the following cycle, and the state stays IDLE.
REQ-030 SHALL cover: PRESET=3, CTRL=0xB (auto-reload) -> irq pulses 1 cycle high every 6 cycles for 5 periods.
REQ-031 SHALL cover: CTRL=0x1 (IM=0) with PRESET=2 -> irq stays 0, CTRL reads 0x0 after expiry, and irq_flag is set internally.
REQ-032 SHALL cover: PRESET=100, EN=1, reset pulled low at COUNT=50 -> all registers read 0 immediately, and there is no irq for 200 cycles after release.
REQ-033 SHALL cover: with TC_PRESCALE_EN, PRESCALE=1, PRESET=2, CTRL=0x9 -> COUNT steps 2,2,1,1,0 and irq rises on the edge at which COUNT becomes 0.
